// File: rtl/quadtree_route_unit_if.sv
// Request/result bus of quadtree_route_unit: request channel in, route result channel out.
// The slave modport is the router's view; the master modport is the driver/consumer view.
`ifndef ROUTER_ADDR_WIDTH
`define ROUTER_ADDR_WIDTH 16
`endif
`ifndef ROUTER_INFO_WIDTH
`define ROUTER_INFO_WIDTH 3
`endif

interface quadtree_route_unit_if #(
    parameter int NUM_CHILD  = 4,
    parameter int ADDR_WIDTH = `ROUTER_ADDR_WIDTH,
    parameter int INFO_WIDTH = `ROUTER_INFO_WIDTH,
    parameter int DIR_WIDTH  = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIR_WIDTH-1:0]  in_dir;
    logic [INFO_WIDTH-1:0] in_info;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic [NUM_CHILD:0]    out_port;
    logic [INFO_WIDTH-1:0] out_info;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  drop_pulse;
    logic                  merge_err;

    modport master (
        output in_valid, in_dir, in_info, in_addr, out_ready,
        input  in_ready, out_valid, out_port, out_info, out_addr, drop_pulse, merge_err
    );

    modport slave (
        input  in_valid, in_dir, in_info, in_addr, out_ready,
        output in_ready, out_valid, out_port, out_info, out_addr, drop_pulse, merge_err
    );
endinterface

// File: rtl/quadtree_route_unit.sv
// Registered routing stage of the quadtree NoC: decodes {dir, info, addr} into a port mask.
// Optional child-FIN merging is enabled by defining RC_FIN_MERGE_EN.
`ifndef ROUTER_ADDR_WIDTH
`define ROUTER_ADDR_WIDTH 16
`endif
`ifndef ROUTER_INFO_WIDTH
`define ROUTER_INFO_WIDTH 3
`endif
`ifndef ROUTER_INFO_CONFIG
`define ROUTER_INFO_CONFIG 0
`endif
`ifndef ROUTER_INFO_READ
`define ROUTER_INFO_READ 1
`endif
`ifndef ROUTER_INFO_CALC
`define ROUTER_INFO_CALC 2
`endif
`ifndef ROUTER_INFO_BROADCAST
`define ROUTER_INFO_BROADCAST 3
`endif
`ifndef ROUTER_INFO_FIN_BROADCAST
`define ROUTER_INFO_FIN_BROADCAST 4
`endif
`ifndef ROUTER_INFO_FIN_COMP
`define ROUTER_INFO_FIN_COMP 5
`endif

module quadtree_route_unit #(
    parameter int LEVEL_IDX  = 0,
    parameter int NUM_CHILD  = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int ADDR_WIDTH = `ROUTER_ADDR_WIDTH,
    parameter int INFO_WIDTH = `ROUTER_INFO_WIDTH,
    parameter int DIR_WIDTH  = 3
) (
    input logic                  clk,
    input logic                  rst,
    quadtree_route_unit_if.slave bus
);
    localparam int PORT_W  = NUM_CHILD + 1;
    localparam int SEL_MSB = ADDR_WIDTH - 1 - LEVEL_IDX * SEL_WIDTH;
    localparam bit IS_ROOT = (LEVEL_IDX == 0);

    localparam logic [INFO_WIDTH-1:0] INFO_CONFIG   = INFO_WIDTH'(`ROUTER_INFO_CONFIG);
    localparam logic [INFO_WIDTH-1:0] INFO_READ     = INFO_WIDTH'(`ROUTER_INFO_READ);
    localparam logic [INFO_WIDTH-1:0] INFO_CALC     = INFO_WIDTH'(`ROUTER_INFO_CALC);
    localparam logic [INFO_WIDTH-1:0] INFO_BCAST    = INFO_WIDTH'(`ROUTER_INFO_BROADCAST);
    localparam logic [INFO_WIDTH-1:0] INFO_FIN_BC   = INFO_WIDTH'(`ROUTER_INFO_FIN_BROADCAST);
    localparam logic [INFO_WIDTH-1:0] INFO_FIN_COMP = INFO_WIDTH'(`ROUTER_INFO_FIN_COMP);

    localparam logic [PORT_W-1:0] CHILD_ALL   = {1'b0, {NUM_CHILD{1'b1}}};
    localparam logic [PORT_W-1:0] PARENT_ONLY = {1'b1, {NUM_CHILD{1'b0}}};

    logic                  in_ready_p0;
    logic                  accept_p0;
    logic [SEL_WIDTH-1:0]  sel_p0;
    logic                  sel_ok_p0;
    logic                  from_local_p0;
    logic                  from_child_p0;
    logic [PORT_W-1:0]     base_mask_p0;
    logic                  sel_err_p0;
    logic [PORT_W-1:0]     route_mask_p0;
    logic                  err_p0;

    logic                  vld_p1;
    logic [PORT_W-1:0]     port_p1;
    logic [INFO_WIDTH-1:0] info_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic                  drop_p1;
    logic                  err_p1;

    // ---- stage p0: request decode ----
    assign in_ready_p0   = !vld_p1 || bus.out_ready;
    assign accept_p0     = bus.in_valid && in_ready_p0;
    assign sel_p0        = bus.in_addr[SEL_MSB -: SEL_WIDTH];
    assign sel_ok_p0     = (32'(sel_p0) < NUM_CHILD);
    assign from_local_p0 = (32'(bus.in_dir) == NUM_CHILD);
    assign from_child_p0 = (32'(bus.in_dir) < NUM_CHILD);

    always_comb begin
        base_mask_p0 = '0;
        sel_err_p0   = 1'b0;
        if (from_local_p0) begin
            case (bus.in_info)
                INFO_CONFIG, INFO_READ: begin
                    if (sel_ok_p0) base_mask_p0 = PORT_W'(1) << sel_p0;
                    else           sel_err_p0   = 1'b1;
                end
                INFO_CALC, INFO_FIN_BC, INFO_FIN_COMP: base_mask_p0 = CHILD_ALL;
                INFO_BCAST:   base_mask_p0 = IS_ROOT ? '0 : CHILD_ALL;
                default:      base_mask_p0 = '0;
            endcase
        end else if (from_child_p0) begin
            case (bus.in_info)
                // The root reflects a child broadcast back down to every child.
                INFO_BCAST:   base_mask_p0 = IS_ROOT ? CHILD_ALL : PARENT_ONLY;
                INFO_READ, INFO_FIN_BC, INFO_FIN_COMP: base_mask_p0 = PARENT_ONLY;
                default:      base_mask_p0 = '0;
            endcase
        end
    end

`ifdef RC_FIN_MERGE_EN
    logic [NUM_CHILD-1:0] fin_bc_map;
    logic [NUM_CHILD-1:0] fin_comp_map;
    logic                 is_comp_p0;
    logic                 child_fin_p0;
    logic [NUM_CHILD-1:0] dir_bit_p0;
    logic [NUM_CHILD-1:0] map_cur_p0;
    logic [NUM_CHILD-1:0] map_set_p0;
    logic                 fin_dup_p0;
    logic                 fin_done_p0;

    always_comb begin
        is_comp_p0    = (bus.in_info == INFO_FIN_COMP);
        child_fin_p0  = from_child_p0 && (is_comp_p0 || (bus.in_info == INFO_FIN_BC));
        dir_bit_p0    = NUM_CHILD'(1) << bus.in_dir;
        map_cur_p0    = is_comp_p0 ? fin_comp_map : fin_bc_map;
        map_set_p0    = map_cur_p0 | dir_bit_p0;
        fin_dup_p0    = child_fin_p0 && (|(map_cur_p0 & dir_bit_p0));
        fin_done_p0   = child_fin_p0 && !fin_dup_p0 && (&map_set_p0);
        // Only the FIN completing the subtree reaches the parent; all others are absorbed.
        route_mask_p0 = (child_fin_p0 && !fin_done_p0) ? '0 : base_mask_p0;
        err_p0        = sel_err_p0 || fin_dup_p0;
    end

    // Bitmaps move only on acceptance, so a stalled completing FIN leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            fin_bc_map   <= '0;
            fin_comp_map <= '0;
        end else if (accept_p0 && child_fin_p0 && !fin_dup_p0) begin
            if (is_comp_p0) fin_comp_map <= fin_done_p0 ? '0 : map_set_p0;
            else            fin_bc_map   <= fin_done_p0 ? '0 : map_set_p0;
        end
    end
`else
    assign route_mask_p0 = base_mask_p0;
    assign err_p0        = sel_err_p0;
`endif

    // ---- stage p1: output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            port_p1 <= '0;
            info_p1 <= '0;
            addr_p1 <= '0;
            drop_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            drop_p1 <= accept_p0 && (route_mask_p0 == '0);
            if (accept_p0 && err_p0) err_p1 <= 1'b1;
            if (accept_p0) begin
                vld_p1 <= |route_mask_p0;
                if (|route_mask_p0) begin
                    port_p1 <= route_mask_p0;
                    info_p1 <= bus.in_info;
                    addr_p1 <= bus.in_addr;
                end
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_p0;
    assign bus.out_valid  = vld_p1;
    assign bus.out_port   = port_p1;
    assign bus.out_info   = info_p1;
    assign bus.out_addr   = addr_p1;
    assign bus.drop_pulse = drop_p1;
    assign bus.merge_err  = err_p1;
endmodule

// File: tb/tb_quadtree_route_unit.sv
// Directed bench for quadtree_route_unit: a root and a level-1 router (4 children) plus a
// 3-child root for the out-of-range select case. Merge scenarios run when RC_FIN_MERGE_EN is set.
module tb_quadtree_route_unit;
    localparam logic [2:0] I_CONFIG   = 3'd0;
    localparam logic [2:0] I_READ     = 3'd1;
    localparam logic [2:0] I_CALC     = 3'd2;
    localparam logic [2:0] I_BCAST    = 3'd3;
    localparam logic [2:0] I_FIN_BC   = 3'd4;
    localparam logic [2:0] I_FIN_COMP = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    quadtree_route_unit_if #(.NUM_CHILD(4)) r_if ();
    quadtree_route_unit_if #(.NUM_CHILD(4)) l_if ();
    quadtree_route_unit_if #(.NUM_CHILD(3)) n_if ();

    quadtree_route_unit #(.LEVEL_IDX(0), .NUM_CHILD(4)) u_root (.clk(clk), .rst(rst), .bus(r_if));
    quadtree_route_unit #(.LEVEL_IDX(1), .NUM_CHILD(4)) u_lvl1 (.clk(clk), .rst(rst), .bus(l_if));
    quadtree_route_unit #(.LEVEL_IDX(0), .NUM_CHILD(3)) u_n3   (.clk(clk), .rst(rst), .bus(n_if));

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Presents one request for exactly one edge (ready is expected high) and returns at edge+1.
    task automatic send(input int u, input logic [2:0] dir, input logic [2:0] info,
                        input logic [15:0] addr);
        case (u)
            0: begin r_if.in_dir = dir; r_if.in_info = info; r_if.in_addr = addr; r_if.in_valid = 1'b1; end
            1: begin l_if.in_dir = dir; l_if.in_info = info; l_if.in_addr = addr; l_if.in_valid = 1'b1; end
            default: begin n_if.in_dir = dir; n_if.in_info = info; n_if.in_addr = addr; n_if.in_valid = 1'b1; end
        endcase
        @(posedge clk); #1;
        r_if.in_valid = 1'b0;
        l_if.in_valid = 1'b0;
        n_if.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        r_if.in_valid = 1'b1; r_if.in_dir = 3'd4; r_if.in_info = I_CALC; r_if.in_addr = 16'hFFFF;
        @(posedge clk); #1;
        r_if.in_valid = 1'b0;
        do_reset();
        total++; if (r_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", r_if.out_valid); end
        total++; if (r_if.out_port !== 5'b0) begin bad++; $display("FAIL reset_port got=%b exp=00000", r_if.out_port); end
        total++; if (r_if.out_info !== 3'b0) begin bad++; $display("FAIL reset_info got=%h exp=0", r_if.out_info); end
        total++; if (r_if.out_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", r_if.out_addr); end
        total++; if (r_if.drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b exp=0", r_if.drop_pulse); end
        total++; if (r_if.merge_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", r_if.merge_err); end
        total++; if (r_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", r_if.in_ready); end
        total++; if (l_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_l_valid got=%b exp=0", l_if.out_valid); end
    endtask

    task automatic test_unicast();
        send(0, 3'd4, I_CONFIG, 16'h8000);
        total++; if (r_if.out_valid !== 1'b1) begin bad++; $display("FAIL cfg_valid got=%b exp=1", r_if.out_valid); end
        total++; if (r_if.out_port !== 5'b00100) begin bad++; $display("FAIL cfg_port got=%b exp=00100", r_if.out_port); end
        total++; if (r_if.out_addr !== 16'h8000) begin bad++; $display("FAIL cfg_addr got=%h exp=8000", r_if.out_addr); end
        send(1, 3'd4, I_READ, 16'h3000);
        total++; if (l_if.out_port !== 5'b01000) begin bad++; $display("FAIL read_local_port got=%b exp=01000", l_if.out_port); end
        total++; if (l_if.out_info !== I_READ) begin bad++; $display("FAIL read_local_info got=%h exp=%h", l_if.out_info, I_READ); end
        send(1, 3'd2, I_READ, 16'h3000);
        total++; if (l_if.out_port !== 5'b10000) begin bad++; $display("FAIL read_child_port got=%b exp=10000", l_if.out_port); end
        total++; if (l_if.out_valid !== 1'b1) begin bad++; $display("FAIL read_child_valid got=%b exp=1", l_if.out_valid); end
        @(posedge clk); #1;
        total++; if (l_if.out_valid !== 1'b0) begin bad++; $display("FAIL read_consumed got=%b exp=0", l_if.out_valid); end
    endtask

    task automatic test_broadcast();
        send(0, 3'd4, I_CALC, 16'h0000);
        total++; if (r_if.out_port !== 5'b01111) begin bad++; $display("FAIL calc_port got=%b exp=01111", r_if.out_port); end
        send(0, 3'd1, I_BCAST, 16'h0000);
        total++; if (r_if.out_port !== 5'b01111 || r_if.out_valid !== 1'b1) begin bad++; $display("FAIL reflect_port got=%b/%b exp=01111/1", r_if.out_port, r_if.out_valid); end
        send(0, 3'd4, I_BCAST, 16'h0000);
        total++; if (r_if.out_valid !== 1'b0) begin bad++; $display("FAIL root_bcast_valid got=%b exp=0", r_if.out_valid); end
        total++; if (r_if.drop_pulse !== 1'b1) begin bad++; $display("FAIL root_bcast_drop got=%b exp=1", r_if.drop_pulse); end
        @(posedge clk); #1;
        total++; if (r_if.drop_pulse !== 1'b0) begin bad++; $display("FAIL drop_one_cycle got=%b exp=0", r_if.drop_pulse); end
        send(1, 3'd0, I_BCAST, 16'h0000);
        total++; if (l_if.out_port !== 5'b10000) begin bad++; $display("FAIL lvl1_bcast_up got=%b exp=10000", l_if.out_port); end
        send(1, 3'd4, I_BCAST, 16'h0000);
        total++; if (l_if.out_port !== 5'b01111) begin bad++; $display("FAIL lvl1_bcast_down got=%b exp=01111", l_if.out_port); end
        send(0, 3'd4, 3'd7, 16'h8000);
        total++; if (r_if.drop_pulse !== 1'b1 || r_if.out_valid !== 1'b0) begin bad++; $display("FAIL unknown_info got=%b/%b exp=1/0", r_if.drop_pulse, r_if.out_valid); end
        send(0, 3'd6, I_CONFIG, 16'h8000);
        total++; if (r_if.drop_pulse !== 1'b1 || r_if.out_valid !== 1'b0) begin bad++; $display("FAIL bad_dir got=%b/%b exp=1/0", r_if.drop_pulse, r_if.out_valid); end
        total++; if (r_if.merge_err !== 1'b0) begin bad++; $display("FAIL bad_dir_err got=%b exp=0", r_if.merge_err); end
    endtask

    task automatic test_select_range();
        send(2, 3'd3, I_READ, 16'h4000);
        total++; if (n_if.out_port !== 4'b0010) begin bad++; $display("FAIL n3_read_port got=%b exp=0010", n_if.out_port); end
        total++; if (n_if.merge_err !== 1'b0) begin bad++; $display("FAIL n3_err_clean got=%b exp=0", n_if.merge_err); end
        send(2, 3'd3, I_CONFIG, 16'hC000);
        total++; if (n_if.out_valid !== 1'b0 || n_if.drop_pulse !== 1'b1) begin bad++; $display("FAIL n3_oor_drop got=%b/%b exp=0/1", n_if.out_valid, n_if.drop_pulse); end
        total++; if (n_if.merge_err !== 1'b1) begin bad++; $display("FAIL n3_oor_err got=%b exp=1", n_if.merge_err); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (n_if.merge_err !== 1'b1) begin bad++; $display("FAIL n3_err_sticky got=%b exp=1", n_if.merge_err); end
    endtask

    task automatic test_backpressure();
        r_if.out_ready = 1'b0;
        send(0, 3'd4, I_CONFIG, 16'h8000);
        total++; if (r_if.out_port !== 5'b00100 || r_if.out_valid !== 1'b1) begin bad++; $display("FAIL bp_first got=%b/%b exp=00100/1", r_if.out_port, r_if.out_valid); end
        r_if.in_dir = 3'd4; r_if.in_info = I_CALC; r_if.in_addr = 16'h1234; r_if.in_valid = 1'b1;
        #1;
        total++; if (r_if.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", r_if.in_ready); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (r_if.out_port !== 5'b00100 || r_if.out_addr !== 16'h8000 || r_if.out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_hold got=%b/%h/%b exp=00100/8000/1", r_if.out_port, r_if.out_addr, r_if.out_valid);
        end
        r_if.out_ready = 1'b1;
        #1;
        total++; if (r_if.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", r_if.in_ready); end
        @(posedge clk); #1;
        r_if.in_valid = 1'b0;
        total++; if (r_if.out_port !== 5'b01111 || r_if.out_addr !== 16'h1234 || r_if.out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_second got=%b/%h/%b exp=01111/1234/1", r_if.out_port, r_if.out_addr, r_if.out_valid);
        end
        @(posedge clk); #1;
        total++; if (r_if.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", r_if.out_valid); end
    endtask

`ifndef RC_FIN_MERGE_EN
    task automatic test_fin_forward();
        send(1, 3'd0, I_FIN_COMP, 16'h0000);
        total++; if (l_if.out_port !== 5'b10000 || l_if.out_valid !== 1'b1) begin bad++; $display("FAIL fwd_comp got=%b/%b exp=10000/1", l_if.out_port, l_if.out_valid); end
        send(1, 3'd3, I_FIN_BC, 16'h0000);
        total++; if (l_if.out_port !== 5'b10000 || l_if.out_info !== I_FIN_BC) begin bad++; $display("FAIL fwd_bc got=%b/%h exp=10000/%h", l_if.out_port, l_if.out_info, I_FIN_BC); end
        send(1, 3'd0, I_FIN_COMP, 16'h0000);
        total++; if (l_if.out_valid !== 1'b1 || l_if.merge_err !== 1'b0) begin bad++; $display("FAIL fwd_repeat got=%b/%b exp=1/0", l_if.out_valid, l_if.merge_err); end
        send(0, 3'd2, I_FIN_COMP, 16'h0000);
        total++; if (r_if.out_port !== 5'b10000) begin bad++; $display("FAIL fwd_root got=%b exp=10000", r_if.out_port); end
        send(1, 3'd4, I_FIN_COMP, 16'h0000);
        total++; if (l_if.out_port !== 5'b01111) begin bad++; $display("FAIL local_fin got=%b exp=01111", l_if.out_port); end
    endtask
`else
    task automatic test_fin_merge();
        logic [2:0] kids [4];
        kids[0] = 3'd0; kids[1] = 3'd1; kids[2] = 3'd1; kids[3] = 3'd3;
        for (int i = 0; i < 4; i++) begin
            send(1, kids[i], I_FIN_COMP, 16'h0000);
            total++; if (l_if.out_valid !== 1'b0 || l_if.drop_pulse !== 1'b1) begin
                bad++; $display("FAIL merge_absorb%0d got=%b/%b exp=0/1", i, l_if.out_valid, l_if.drop_pulse);
            end
            total++; if (l_if.merge_err !== (i >= 2)) begin
                bad++; $display("FAIL merge_err%0d got=%b exp=%b", i, l_if.merge_err, (i >= 2));
            end
        end
        send(1, 3'd2, I_FIN_COMP, 16'h0000);
        total++; if (l_if.out_valid !== 1'b1 || l_if.out_port !== 5'b10000) begin bad++; $display("FAIL merge_emit got=%b/%b exp=1/10000", l_if.out_valid, l_if.out_port); end
        send(1, 3'd0, I_FIN_COMP, 16'h0000);
        total++; if (l_if.out_valid !== 1'b0 || l_if.drop_pulse !== 1'b1) begin bad++; $display("FAIL merge_cleared got=%b/%b exp=0/1", l_if.out_valid, l_if.drop_pulse); end
        for (int c = 0; c < 4; c++) begin
            send(1, 3'(c), I_FIN_BC, 16'h0000);
            total++; if (l_if.out_valid !== (c == 3)) begin bad++; $display("FAIL merge_bc%0d got=%b exp=%b", c, l_if.out_valid, (c == 3)); end
        end
    endtask

    task automatic test_reset_mid_merge();
        int outs;
        do_reset();
        send(1, 3'd0, I_FIN_COMP, 16'h0000);
        send(1, 3'd1, I_FIN_COMP, 16'h0000);
        do_reset();
        total++; if (l_if.out_valid !== 1'b0 || l_if.out_port !== 5'b0 || l_if.drop_pulse !== 1'b0) begin
            bad++; $display("FAIL midrst_zero got=%b/%b/%b exp=0/00000/0", l_if.out_valid, l_if.out_port, l_if.drop_pulse);
        end
        outs = 0;
        for (int c = 0; c < 4; c++) begin
            send(1, 3'(c), I_FIN_COMP, 16'h0000);
            if (l_if.out_valid === 1'b1) outs++;
        end
        total++; if (outs != 1) begin bad++; $display("FAIL midrst_count got=%0d exp=1", outs); end
        total++; if (l_if.merge_err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", l_if.merge_err); end
    endtask
`endif

    initial begin
        r_if.in_valid = 1'b0; r_if.in_dir = '0; r_if.in_info = '0; r_if.in_addr = '0; r_if.out_ready = 1'b1;
        l_if.in_valid = 1'b0; l_if.in_dir = '0; l_if.in_info = '0; l_if.in_addr = '0; l_if.out_ready = 1'b1;
        n_if.in_valid = 1'b0; n_if.in_dir = '0; n_if.in_info = '0; n_if.in_addr = '0; n_if.out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_unicast();
        test_broadcast();
        test_select_range();
        test_backpressure();
`ifndef RC_FIN_MERGE_EN
        test_fin_forward();
`else
        test_fin_merge();
        test_reset_mid_merge();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
